// File: rtl/midi_pkg.sv
// Purpose: shared MIDI definitions for the receive parser and the volume
//          sender: byte-class boundaries, command nibbles, the CC number
//          for channel volume, the parser state enum and a byte classifier.
// Ports:   none (package).
package midi_pkg;

  // Byte-class boundaries
  localparam logic [7:0] STATUS_MIN  = 8'h80;  // 0x80-0xEF channel status
  localparam logic [7:0] SYSEX_START = 8'hF0;  // SysEx start
  localparam logic [7:0] SYSEX_END   = 8'hF7;  // SysEx end (system common)
  localparam logic [7:0] RT_MIN      = 8'hF8;  // 0xF8-0xFF real-time

  // Channel-voice command nibbles (status[7:4])
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_VOLUME = 7'd7;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SYSEX     = 2'd3
  } parser_state_e;

  typedef enum logic [2:0] {
    BC_DATA,
    BC_CHAN,
    BC_SYSEX,
    BC_COMMON,
    BC_RT
  } byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    if (b < STATUS_MIN)       return BC_DATA;
    else if (b < SYSEX_START) return BC_CHAN;
    else if (b == SYSEX_START) return BC_SYSEX;
    else if (b < RT_MIN)      return BC_COMMON;  // includes SYSEX_END
    else                      return BC_RT;
  endfunction

endpackage

// File: rtl/midi_gap_timer.sv
// Purpose: saturating idle-gap counter. Counts while enable is high,
//          clears (with priority) on clear, holds at LIMIT and flags expired.
// Ports:   clk, rst_n  - clock, async active-low reset
//          clear       - synchronous clear of the count
//          enable      - count this cycle
//          expired     - count has reached LIMIT
module midi_gap_timer #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != W'(LIMIT))) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired = (count_q == W'(LIMIT));

endmodule

// File: rtl/midi_message_parser.sv
// Purpose: receive-side MIDI decoder. Reassembles channel-voice messages
//          (with running status) from UART bytes and emits registered
//          one-cycle strobes for Control Change and Note On/Off on the
//          selected channel (or all channels when OMNI). Tracks CC#7 as a
//          live volume register.
// Ports:   clk, rst_n              - clock, async active-low reset
//          rx_byte/rx_valid        - received byte and its strobe
//          rx_error                - UART framing-error strobe
//          cc_valid/cc_num/cc_value
//          note_valid/note_on/note_key/note_vel
//          volume_level            - last CC#7 value on accepted channel
//          msg_dropped             - partial message discarded strobe
module midi_message_parser
  import midi_pkg::*;
#(
  parameter logic [3:0]  CHANNEL        = 4'd0,
  parameter logic        OMNI           = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [6:0]  VOL_RESET      = 7'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       cc_valid,
  output logic [6:0] cc_num,
  output logic [6:0] cc_value,
  output logic       note_valid,
  output logic       note_on,
  output logic [6:0] note_key,
  output logic [6:0] note_vel,
  output logic [6:0] volume_level,
  output logic       msg_dropped
);

  parser_state_e state_q, state_d;
  logic [7:0]    status_q, status_d;   // running status, 0 = none
  logic [6:0]    d1_q, d1_d;
  logic          pending_q, pending_d; // status seen, no data byte yet

  logic       cc_valid_q, cc_valid_d;
  logic [6:0] cc_num_q, cc_num_d, cc_value_q, cc_value_d;
  logic       note_valid_q, note_valid_d, note_on_q, note_on_d;
  logic [6:0] note_key_q, note_key_d, note_vel_q, note_vel_d;
  logic [6:0] volume_q, volume_d;
  logic       dropped_q, dropped_d;

  byte_class_e bclass;
  logic        partial;
  logic        chan_match;
  logic [3:0]  cmd;
  logic        timer_clear;
  logic        timer_expired;

  assign bclass     = classify(rx_byte);
  assign cmd        = status_q[7:4];
  assign chan_match = OMNI || (status_q[3:0] == CHANNEL);
  // Something is half-received: waiting on d2, or a status with no data yet.
  assign partial    = (state_q == WAIT_D2) || ((state_q == WAIT_D1) && pending_q);
  // Real-time bytes must leave the gap timer untouched.
  assign timer_clear = rx_error || (rx_valid && (bclass != BC_RT));

  midi_gap_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (state_q == WAIT_D2),
    .expired (timer_expired)
  );

  // NOTE: every variable driven here gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    d1_d         = d1_q;
    pending_d    = pending_q;
    cc_valid_d   = 1'b0;
    cc_num_d     = cc_num_q;
    cc_value_d   = cc_value_q;
    note_valid_d = 1'b0;
    note_on_d    = note_on_q;
    note_key_d   = note_key_q;
    note_vel_d   = note_vel_q;
    volume_d     = volume_q;
    dropped_d    = 1'b0;

    if (rx_error) begin
      // Error wins over a coincident byte; that byte is lost.
      state_d   = NO_STATUS;
      status_d  = '0;
      pending_d = 1'b0;
      dropped_d = partial;
    end else if (rx_valid && (bclass != BC_RT)) begin
      unique case (bclass)
        BC_CHAN: begin
          dropped_d = partial;
          status_d  = rx_byte;
          pending_d = 1'b1;
          state_d   = WAIT_D1;
        end
        BC_SYSEX: begin
          dropped_d = partial;
          status_d  = '0;
          pending_d = 1'b0;
          state_d   = SYSEX;
        end
        BC_COMMON: begin
          dropped_d = partial;
          status_d  = '0;
          pending_d = 1'b0;
          state_d   = NO_STATUS;
        end
        default: begin  // BC_DATA
          unique case (state_q)
            WAIT_D1: begin
              pending_d = 1'b0;
              // One-data-byte commands complete here and carry no output.
              if ((cmd != PROG) && (cmd != CHPRESS)) begin
                d1_d    = rx_byte[6:0];
                state_d = WAIT_D2;
              end
            end
            WAIT_D2: begin
              state_d = WAIT_D1;
              if (chan_match) begin
                unique case (cmd)
                  NOTE_ON, NOTE_OFF: begin
                    note_valid_d = 1'b1;
                    note_on_d    = (cmd == NOTE_ON) && (rx_byte[6:0] != 7'd0);
                    note_key_d   = d1_q;
                    note_vel_d   = rx_byte[6:0];
                  end
                  CC: begin
                    cc_valid_d = 1'b1;
                    cc_num_d   = d1_q;
                    cc_value_d = rx_byte[6:0];
                    if (d1_q == CC_VOLUME) volume_d = rx_byte[6:0];
                  end
                  default: ;  // aftertouch / pitch bend: parsed, no output
                endcase
              end
            end
            default: ;  // NO_STATUS and SYSEX ignore data bytes
          endcase
        end
      endcase
    end else if ((state_q == WAIT_D2) && timer_expired) begin
      // Stale half-message: drop it but keep running status.
      dropped_d = 1'b1;
      state_d   = WAIT_D1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NO_STATUS;
      status_q     <= '0;
      d1_q         <= '0;
      pending_q    <= 1'b0;
      cc_valid_q   <= 1'b0;
      cc_num_q     <= '0;
      cc_value_q   <= '0;
      note_valid_q <= 1'b0;
      note_on_q    <= 1'b0;
      note_key_q   <= '0;
      note_vel_q   <= '0;
      volume_q     <= VOL_RESET;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      d1_q         <= d1_d;
      pending_q    <= pending_d;
      cc_valid_q   <= cc_valid_d;
      cc_num_q     <= cc_num_d;
      cc_value_q   <= cc_value_d;
      note_valid_q <= note_valid_d;
      note_on_q    <= note_on_d;
      note_key_q   <= note_key_d;
      note_vel_q   <= note_vel_d;
      volume_q     <= volume_d;
      dropped_q    <= dropped_d;
    end
  end

  assign cc_valid     = cc_valid_q;
  assign cc_num       = cc_num_q;
  assign cc_value     = cc_value_q;
  assign note_valid   = note_valid_q;
  assign note_on      = note_on_q;
  assign note_key     = note_key_q;
  assign note_vel     = note_vel_q;
  assign volume_level = volume_q;
  assign msg_dropped  = dropped_q;

endmodule
